// File: rtl/param_transposed_fir.sv
// param_transposed_fir: parametrised transposed-form FIR filter.
// Coefficients go into a shadow bank through a write port and become active on
// coeff_commit. All datapath state advances only on in_valid cycles. The settled
// flag goes high once TAPS samples have passed since the last commit or reset.
// Optional build macro: FIR_SATURATE_EN clamps the output to the OUT_W range.
// When the macro is not defined, the output wraps in two's complement.
module param_transposed_fir #(
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 16,
  parameter int TAPS      = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   data_in,
  input  logic                       coeff_wr_en,
  input  logic [$clog2(TAPS)-1:0]    coeff_wr_addr,
  input  logic signed [COEFF_W-1:0]  coeff_wr_data,
  input  logic                       coeff_commit,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    data_out,
  output logic                       settled
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam int CW     = $clog2(TAPS + 1);
  localparam logic [CW-1:0] TAPS_C = CW'(TAPS);

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
`endif

  // Full-precision signed product, sign-extended to accumulator width.
  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic signed [DATA_W-1:0]  x,
    input logic signed [COEFF_W-1:0] c
  );
    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] ce;
    logic signed [PROD_W-1:0] p;
    xe = {{COEFF_W{x[DATA_W-1]}}, x};
    ce = {{DATA_W{c[COEFF_W-1]}}, c};
    p  = xe * ce;
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Scale the accumulator down to output width, either clamping or wrapping.
  function automatic logic signed [OUT_W-1:0] scale_out(
    input logic signed [ACC_W-1:0] acc_in
  );
    logic signed [ACC_W-1:0] sh;
    sh = acc_in >>> OUT_SHIFT;
`ifdef FIR_SATURATE_EN
    if (sh > OUT_MAX_A) begin
      return OUT_MAX;
    end else if (sh < OUT_MIN_A) begin
      return OUT_MIN;
    end else begin
      return sh[OUT_W-1:0];
    end
`else
    return sh[OUT_W-1:0];
`endif
  endfunction

  logic signed [COEFF_W-1:0] shadow_q [TAPS];
  logic signed [COEFF_W-1:0] shadow_d [TAPS];
  logic signed [COEFF_W-1:0] active_q [TAPS];
  logic signed [COEFF_W-1:0] active_d [TAPS];
  // psum_q[k-1] holds transposed partial sum s[k], for k = 1..TAPS-1.
  logic signed [ACC_W-1:0]   psum_q   [TAPS-1];
  logic signed [ACC_W-1:0]   psum_d   [TAPS-1];
  logic signed [ACC_W-1:0]   prod     [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [OUT_W-1:0]   data_out_q, data_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      settled_q, settled_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  // Next-state logic: coefficient banks, transposed partial sums, output and settle count.
  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    psum_d      = psum_q;
    data_out_d  = data_out_q;
    out_valid_d = in_valid;
    cnt_d       = cnt_q;
    settled_d   = settled_q;

    for (int k = 0; k < TAPS; k++) begin
      if (coeff_wr_en && ({1'b0, coeff_wr_addr} == k[AW:0])) begin
        shadow_d[k] = coeff_wr_data;
      end
    end
    // Commit takes the shadow bank including any write landing this same edge.
    if (coeff_commit) begin
      active_d = shadow_d;
    end

    // Products use the bank active before this edge, so a sample arriving with
    // a commit still sees the old coefficients.
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = mul_ext(data_in, active_q[k]);
    end
    acc = prod[0] + psum_q[0];

    if (in_valid) begin
      for (int k = 0; k < TAPS - 2; k++) begin
        psum_d[k] = prod[k+1] + psum_q[k+1];
      end
      psum_d[TAPS-2] = prod[TAPS-1];
      data_out_d     = scale_out(acc);
    end

    if (coeff_commit) begin
      cnt_d = '0;
    end else if (in_valid && (cnt_q != TAPS_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (in_valid) begin
      settled_d = (cnt_d == TAPS_C);
    end
  end

  // State registers; reset clears all history and both coefficient banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      for (int k = 0; k < TAPS - 1; k++) begin
        psum_q[k] <= '0;
      end
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      settled_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      psum_q      <= psum_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      settled_q   <= settled_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign settled   = settled_q;

endmodule

// File: tb/tb_param_transposed_fir.sv
// Directed testbench for param_transposed_fir (default parameters: 16-bit, 8 taps).
module tb_param_transposed_fir;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] data_in;
  logic               coeff_wr_en;
  logic [2:0]         coeff_wr_addr;
  logic signed [15:0] coeff_wr_data;
  logic               coeff_commit;
  logic               out_valid;
  logic signed [15:0] data_out;
  logic               settled;

  int errors = 0;
  int checks = 0;

  param_transposed_fir #(
    .DATA_W(16), .COEFF_W(16), .TAPS(8), .OUT_W(16), .OUT_SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr),
    .coeff_wr_data(coeff_wr_data), .coeff_commit(coeff_commit),
    .out_valid(out_valid), .data_out(data_out), .settled(settled)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic tick(input logic v, input logic [15:0] x, input logic we,
                      input logic [2:0] wa, input logic [15:0] wd, input logic cm);
    in_valid = v; data_in = x; coeff_wr_en = we; coeff_wr_addr = wa;
    coeff_wr_data = wd; coeff_commit = cm;
    @(posedge clk);
    #1;
    in_valid = 1'b0; coeff_wr_en = 1'b0; coeff_commit = 1'b0; data_in = '0;
  endtask

  task automatic load_all(input logic [15:0] c);
    for (int k = 0; k < 8; k++) tick(1'b0, 16'h0, 1'b1, k[2:0], c, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; coeff_wr_en = 1'b0;
    coeff_wr_addr = '0; coeff_wr_data = '0; coeff_commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got %h want 0000", data_out); end
    checks++; if (settled !== 1'b0) begin errors++; $display("FAIL reset_settled got %0b want 0", settled); end
    rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    logic [15:0] exp_d;
    logic        exp_s;
    for (int k = 0; k < 8; k++) tick(1'b0, 16'h0, 1'b1, k[2:0], 16'(k + 1), 1'b0);
    tick(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, (i == 0) ? 16'h1 : 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
      exp_d = (i < 8) ? 16'(i + 1) : 16'h0;
      exp_s = (i >= 7);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL impulse_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (data_out !== exp_d) begin errors++; $display("FAIL impulse_data[%0d] got %0d want %0d", i, data_out, exp_d); end
      checks++; if (settled !== exp_s) begin errors++; $display("FAIL impulse_settled[%0d] got %0b want %0b", i, settled, exp_s); end
    end
    tick(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL impulse_idle_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_gapped();
    logic [15:0] exp_d;
    load_all(16'h1);
    tick(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      exp_d = (i < 8) ? 16'(i + 1) : 16'd8;
      tick(1'b1, 16'h1, 1'b0, 3'd0, 16'h0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (data_out !== exp_d) begin errors++; $display("FAIL gap_data[%0d] got %0d want %0d", i, data_out, exp_d); end
      checks++; if (settled !== (i >= 7)) begin errors++; $display("FAIL gap_settled[%0d] got %0b want %0b", i, settled, (i >= 7)); end
      tick(1'b0, 16'h1, 1'b0, 3'd0, 16'h0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_idle_valid[%0d] got %0b want 0", i, out_valid); end
      checks++; if (data_out !== exp_d) begin errors++; $display("FAIL gap_hold[%0d] got %0d want %0d", i, data_out, exp_d); end
    end
  endtask

  task automatic test_midstream_commit();
    logic [15:0] exp_d;
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h2, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (data_out !== 16'd16) begin errors++; $display("FAIL mid_steady got %0d want 16", data_out); end
    load_all(16'h2);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 16'h2, 1'b0, 3'd0, 16'h0, 1'b0);
      checks++; if (data_out !== 16'd16) begin errors++; $display("FAIL mid_shadow_only[%0d] got %0d want 16", i, data_out); end
    end
    tick(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      tick(1'b1, 16'h2, 1'b0, 3'd0, 16'h0, 1'b0);
      exp_d = 16'(16 + 2 * j);
      checks++; if (data_out !== exp_d) begin errors++; $display("FAIL mid_data[%0d] got %0d want %0d", j, data_out, exp_d); end
      checks++; if (settled !== (j == 8)) begin errors++; $display("FAIL mid_settled[%0d] got %0b want %0b", j, settled, (j == 8)); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_first;
    logic [15:0] exp_last;
`ifdef FIR_SATURATE_EN
    exp_first = 16'h7FFF;
    exp_last  = 16'h7FFF;
`else
    exp_first = 16'h001D;
    exp_last  = 16'h0008;
`endif
    load_all(16'h7FFF);
    tick(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 16'h7FFF, 1'b0, 3'd0, 16'h0, 1'b0);
      if (i == 0) begin
        checks++; if (data_out !== exp_first) begin errors++; $display("FAIL ovf_first got %h want %h", data_out, exp_first); end
      end
    end
    checks++; if (data_out !== exp_last) begin errors++; $display("FAIL ovf_settled_data got %h want %h", data_out, exp_last); end
    checks++; if (settled !== 1'b1) begin errors++; $display("FAIL ovf_settled got %0b want 1", settled); end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 16'h7FFF, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %0b want 1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b want 0", out_valid); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL areset_data got %h want 0000", data_out); end
    checks++; if (settled !== 1'b0) begin errors++; $display("FAIL areset_settled got %0b want 0", settled); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1, 16'h5, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (out_valid !== 1'b1 || data_out !== 16'h0) begin errors++; $display("FAIL areset_post got v=%0b d=%0d want v=1 d=0", out_valid, data_out); end
    tick(1'b0, 16'h0, 1'b1, 3'd0, 16'd7, 1'b0);
    tick(1'b1, 16'h5, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL areset_uncommitted got %0d want 0", data_out); end
  endtask

  task automatic test_commit_timing();
    // Shadow holds c[0]=7 from before; write c[1]=3 with commit on the same edge.
    tick(1'b0, 16'h0, 1'b1, 3'd1, 16'd3, 1'b1);
    tick(1'b1, 16'h1, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (data_out !== 16'd7) begin errors++; $display("FAIL wr_commit_same got %0d want 7", data_out); end
    // Commit together with a sample: this sample still uses c[0]=7, c[1]=3.
    tick(1'b1, 16'h0, 1'b1, 3'd0, 16'd4, 1'b1);
    checks++; if (data_out !== 16'd3) begin errors++; $display("FAIL commit_with_sample got %0d want 3", data_out); end
    checks++; if (settled !== 1'b0) begin errors++; $display("FAIL commit_with_sample_settled got %0b want 0", settled); end
    tick(1'b1, 16'h1, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (data_out !== 16'd4) begin errors++; $display("FAIL commit_new_set got %0d want 4", data_out); end
    for (int i = 0; i < 6; i++) tick(1'b1, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (settled !== 1'b0) begin errors++; $display("FAIL commit_count7_settled got %0b want 0", settled); end
    tick(1'b1, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    checks++; if (settled !== 1'b1) begin errors++; $display("FAIL commit_count8_settled got %0b want 1", settled); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_gapped();
    test_midstream_commit();
    test_overflow();
    test_async_reset();
    test_commit_timing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
